// File: rtl/scan_controller.sv
// rtl/scan_controller.sv - reads a program header, then runs triggered or free-running scans over the program bytes
// Optional idle-byte watchdog in RUN is enabled by defining SCAN_WDOG_EN.
module scan_controller #(
   parameter int ADDR_W   = 10,
   parameter int WDOG_CYC = 4095
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trig_in,
   input  logic              auto_mode,
   input  logic              rd_ready,
   input  logic [7:0]        rd_byte,
   output logic              restart,
   output logic [ADDR_W-1:0] start_addr,
   output logic              instr_valid,
   output logic [7:0]        instr,
   output logic              in_latch,
   output logic              scan_done,
   output logic              busy,
   output logic              fault,
   output logic [7:0]        scan_count
);

   typedef enum logic [2:0] {
      S_HDR,
      S_WAIT,
      S_LATCH,
      S_RUN,
      S_DONE,
      S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        hdr_idx_q, hdr_idx_d;
   logic [7:0]        hi_q, hi_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] hdr_addr;
   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic              sync3_q, sync3_d;
   logic              pending_q, pending_d;
   logic [7:0]        instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic [7:0]        scan_count_q, scan_count_d;
   logic              trig_rise;

`ifdef SCAN_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYC + 1);
   logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
   if (WDOG_CYC < 1) begin : g_wdog_unused
   end
`endif

   // High header byte (b0 or b2) joined with the current low byte
   assign hdr_addr  = ADDR_W'({hi_q, rd_byte});
   assign trig_rise = sync2_q & ~sync3_q;

   always_comb begin
      state_d       = state_q;
      hdr_idx_d     = hdr_idx_q;
      hi_d          = hi_q;
      start_d       = start_q;
      end_d         = end_q;
      cnt_d         = cnt_q;
      sync1_d       = trig_in;
      sync2_d       = sync1_q;
      sync3_d       = sync2_q;
      pending_d     = pending_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      scan_count_d  = scan_count_q;
`ifdef SCAN_WDOG_EN
      wdog_d        = wdog_q;
`endif

      if (trig_rise && (state_q != S_WAIT)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         S_HDR: begin
            if (rd_ready) begin
               hdr_idx_d = hdr_idx_q + 2'd1;
               case (hdr_idx_q)
                  2'd0: hi_d = rd_byte;
                  2'd1: start_d = hdr_addr;
                  2'd2: hi_d = rd_byte;
                  default: begin
                     end_d = hdr_addr;
                     if ((hdr_addr == '0) || (hdr_addr < start_q)) begin
                        state_d = S_FAULT;
                     end else begin
                        state_d = S_WAIT;
                     end
                  end
               endcase
            end
         end
         S_WAIT: begin
            if (auto_mode || pending_q || trig_rise) begin
               state_d   = S_LATCH;
               pending_d = 1'b0;
            end
         end
         S_LATCH: begin
            cnt_d   = '0;
            state_d = S_RUN;
`ifdef SCAN_WDOG_EN
            wdog_d  = '0;
`endif
         end
         S_RUN: begin
            if (rd_ready) begin
               instr_valid_d = 1'b1;
               instr_d       = rd_byte;
`ifdef SCAN_WDOG_EN
               wdog_d        = '0;
`endif
               // cnt_q counts bytes already taken, so the last one is at end-start
               if (cnt_q == (end_q - start_q)) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
`ifdef SCAN_WDOG_EN
               if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
                  state_d = S_FAULT;
               end else begin
                  wdog_d = wdog_q + 1'b1;
               end
`endif
            end
         end
         S_DONE: begin
            scan_count_d = scan_count_q + 8'd1;
            state_d      = S_WAIT;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_HDR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_HDR;
         hdr_idx_q     <= 2'd0;
         hi_q          <= 8'd0;
         start_q       <= '0;
         end_q         <= '0;
         cnt_q         <= '0;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         sync3_q       <= 1'b0;
         pending_q     <= 1'b0;
         instr_q       <= 8'd0;
         instr_valid_q <= 1'b0;
         scan_count_q  <= 8'd0;
      end else begin
         state_q       <= state_d;
         hdr_idx_q     <= hdr_idx_d;
         hi_q          <= hi_d;
         start_q       <= start_d;
         end_q         <= end_d;
         cnt_q         <= cnt_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         sync3_q       <= sync3_d;
         pending_q     <= pending_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         scan_count_q  <= scan_count_d;
      end
   end

`ifdef SCAN_WDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`endif

   assign restart     = (state_q == S_LATCH);
   assign in_latch    = (state_q == S_LATCH);
   assign scan_done   = (state_q == S_DONE);
   assign busy        = (state_q == S_LATCH) || (state_q == S_RUN) || (state_q == S_DONE);
   assign fault       = (state_q == S_FAULT);
   assign start_addr  = start_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign scan_count  = scan_count_q;

endmodule

// File: tb/tb_scan_controller.sv
// tb/tb_scan_controller.sv - self-checking bench for scan_controller (header table, corner sequences, random scans)
module tb_scan_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       trig_in = 1'b0;
   logic       auto_mode = 1'b0;
   logic       rd_ready = 1'b0;
   logic [7:0] rd_byte = 8'd0;
   logic       restart, instr_valid, in_latch, scan_done, busy, fault;
   logic [9:0] start_addr;
   logic [7:0] instr, scan_count;
   logic [31:0] outs_w;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int restart_cnt = 0;
   int done_cnt = 0;

   typedef struct {
      logic [7:0] b;
      int         c;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [31:0] hdr;
      logic        exp_fault;
      logic [9:0]  exp_start;
   } hdr_vec_t;
   hdr_vec_t tbl[8];

   scan_controller #(.ADDR_W(10), .WDOG_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .auto_mode(auto_mode),
      .rd_ready(rd_ready), .rd_byte(rd_byte), .restart(restart), .start_addr(start_addr),
      .instr_valid(instr_valid), .instr(instr), .in_latch(in_latch), .scan_done(scan_done),
      .busy(busy), .fault(fault), .scan_count(scan_count)
   );

   assign outs_w = {restart, start_addr, instr_valid, instr, in_latch, scan_done, busy, fault, scan_count};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every accepted program byte must reappear as instr exactly one cycle after it was offered
   always @(negedge clk) begin : mon
      exp_t e;
      if (instr_valid) begin
         if (exp_q.size() == 0) begin
            check("instr_unexpected", int'(instr_valid), 0);
         end else begin
            e = exp_q.pop_front();
            check("instr_data", int'(instr), int'(e.b));
            check("instr_cycle", cyc, e.c);
         end
      end
      if (restart) restart_cnt++;
      if (scan_done) done_cnt++;
      if (restart || in_latch) check("latch_pair", int'(in_latch), int'(restart));
   end

   initial begin
      #600000;
      $display("FAIL global_timeout actual=%0d expected=finish", cyc);
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rd_ready = 1'b0;
      trig_in = 1'b0;
      step();
      step();
      check("reset_outs", int'(outs_w), 0);
      rst_n = 1'b1;
      step();
   endtask

   task automatic send_hdr(input logic [31:0] hdr, input int maxgap);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, maxgap)) step();
         rd_ready = 1'b1;
         rd_byte = hdr[31-8*i -: 8];
         step();
         rd_ready = 1'b0;
      end
   endtask

   task automatic pulse_trig();
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
   endtask

   task automatic feed(input int n, input int mingap, input int maxgap);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(mingap, maxgap)) step();
         rd_ready = 1'b1;
         rd_byte = 8'($urandom);
         exp_q.push_back('{b: rd_byte, c: cyc + 1});
         step();
         rd_ready = 1'b0;
      end
   endtask

   task automatic wait_restart(input int budget);
      int n = 0;
      while (!restart && n < budget) begin
         step();
         n++;
      end
      check("restart_seen", int'(restart), 1);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!scan_done && n < budget) begin
         step();
         n++;
      end
      check("done_seen", int'(scan_done), 1);
   endtask

   initial begin
      int rc, dc, s, span, nscan, exp_cnt;
      tbl[0] = '{32'h0008_0004, 1'b1, 10'h008};
      tbl[1] = '{32'h0000_0000, 1'b1, 10'h000};
      tbl[2] = '{32'h0005_0005, 1'b0, 10'h005};
      tbl[3] = '{32'h0000_03FF, 1'b0, 10'h000};
      tbl[4] = '{32'hFD10_0200, 1'b0, 10'h110};
      tbl[5] = '{32'h0201_0200, 1'b1, 10'h201};
      tbl[6] = '{32'h03FF_03FF, 1'b0, 10'h3FF};
      tbl[7] = '{32'h0001_FC00, 1'b1, 10'h001};

      step();
      check("por_outs", int'(outs_w), 0);
      rst_n = 1'b1;
      step();

      // Header decode table
      for (int i = 0; i < 8; i++) begin
         do_reset();
         auto_mode = 1'b1;
         send_hdr(tbl[i].hdr, 0);
         check("hdr_fault", int'(fault), int'(tbl[i].exp_fault));
         check("hdr_start", int'(start_addr), int'(tbl[i].exp_start));
         check("hdr_busy", int'(busy), 0);
         step();
         check("hdr_restart", int'(restart), int'(!tbl[i].exp_fault));
         if (tbl[i].exp_fault) begin
            repeat (2) begin
               rd_ready = 1'b1;
               rd_byte = 8'hA5;
               step();
               rd_ready = 1'b0;
            end
            check("fault_sticky", int'(fault), 1);
            check("fault_busy", int'(busy), 0);
         end
      end
      do_reset();
      check("q_empty_tbl", exp_q.size(), 0);

      // Free-running scan of 4 bytes, next scan starts right after
      auto_mode = 1'b1;
      send_hdr(32'h0004_0007, 1);
      wait_restart(5);
      check("latch_inlatch", int'(in_latch), 1);
      step();
      feed(4, 0, 2);
      check("auto_done", int'(scan_done), 1);
      step();
      check("auto_count", int'(scan_count), 1);
      check("auto_wait_busy", int'(busy), 0);
      step();
      check("auto_next_latch", int'(restart), 1);
      do_reset();
      check("q_empty_auto", exp_q.size(), 0);

      // Triggered mode: two edges during RUN give exactly one extra scan
      auto_mode = 1'b0;
      send_hdr(32'h0004_0005, 0);
      repeat (3) step();
      check("trig_idle", int'(busy), 0);
      rc = restart_cnt;
      dc = done_cnt;
      pulse_trig();
      wait_restart(8);
      step();
      pulse_trig();
      repeat (3) step();
      pulse_trig();
      repeat (3) step();
      check("trig_still_run", int'(busy), 1);
      feed(2, 0, 2);
      wait_done(5);
      wait_restart(8);
      step();
      feed(2, 0, 2);
      wait_done(5);
      repeat (20) step();
      check("trig_count", int'(scan_count), 2);
      check("trig_end_wait", int'(busy), 0);
      check("trig_restarts", restart_cnt - rc, 2);
      check("trig_dones", done_cnt - dc, 2);
      check("q_empty_trig", exp_q.size(), 0);

      // scan_count wraps 255 -> 0
      do_reset();
      auto_mode = 1'b1;
      send_hdr(32'h0004_0004, 0);
      for (int k = 0; k < 256; k++) begin
         wait_restart(6);
         step();
         feed(1, 0, 0);
         wait_done(4);
         step();
         if (k == 254) check("count_255", int'(scan_count), 255);
      end
      check("count_wrap", int'(scan_count), 0);

      // Reset in the middle of RUN
      do_reset();
      auto_mode = 1'b1;
      send_hdr(32'h0004_0007, 0);
      wait_restart(5);
      step();
      feed(2, 0, 1);
      #6;
      rst_n = 1'b0;
      #1;
      check("async_reset_outs", int'(outs_w), 0);
      step();
      check("held_reset_outs", int'(outs_w), 0);
      rst_n = 1'b1;
      check("q_empty_rst", exp_q.size(), 0);
      rc = restart_cnt;
      repeat (4) step();
      check("rst_no_restart", restart_cnt - rc, 0);
      send_hdr(32'h0004_0007, 1);
      check("hdr_reread_norestart", restart_cnt - rc, 0);
      step();
      check("hdr_reread_restart", int'(restart), 1);

      // Byte stream stalls mid-RUN
      do_reset();
      auto_mode = 1'b0;
      send_hdr(32'h0000_0009, 0);
      pulse_trig();
      wait_restart(8);
      step();
      feed(3, 0, 1);
      repeat (15) step();
      check("stall_pre_fault", int'(fault), 0);
      step();
`ifdef SCAN_WDOG_EN
      check("wdog_fault", int'(fault), 1);
      check("wdog_busy", int'(busy), 0);
`else
      check("stall_fault", int'(fault), 0);
      check("stall_busy", int'(busy), 1);
`endif
      repeat (20) step();
`ifdef SCAN_WDOG_EN
      check("wdog_sticky", int'(fault), 1);
`else
      check("stall_still_run", int'(busy), 1);
`endif
      check("stall_count", int'(scan_count), 0);

      // Random headers and triggered scans against a transaction-level model
      for (int it = 0; it < 6; it++) begin
         do_reset();
         auto_mode = 1'b0;
         s = $urandom_range(0, 1000);
         span = $urandom_range(1, 12);
         send_hdr({6'($urandom), 2'(s >> 8), 8'(s), 6'($urandom), 2'((s + span - 1) >> 8), 8'(s + span - 1)}, 2);
         check("rnd_start", int'(start_addr), s);
         check("rnd_fault", int'(fault), 0);
         nscan = $urandom_range(1, 3);
         exp_cnt = 0;
         for (int j = 0; j < nscan; j++) begin
            repeat ($urandom_range(0, 2)) begin
               rd_ready = 1'b1;
               rd_byte = 8'($urandom);
               step();
               rd_ready = 1'b0;
            end
            pulse_trig();
            wait_restart(8);
            step();
            feed(span, 0, 3);
            wait_done(5);
            exp_cnt++;
            step();
            check("rnd_count", int'(scan_count), exp_cnt);
         end
         check("q_empty_rnd", exp_q.size(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
